// File: rtl/firebird7_in_gate1_tessent_data_mux_hold_pkg.sv
// Shared types and helpers for the gate1 IJTAG/functional bumpless data mux.
package firebird7_in_gate1_tessent_data_mux_hold_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    OVERRIDE = 2'd2,
    RELEASE  = 2'd3
  } hold_state_e;

  // Hold counter width; at least one bit so a zero-length hold still elaborates.
  function automatic int unsigned cnt_width(input int unsigned hold_cycles);
    return (hold_cycles == 0) ? 1 : $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_hold_ch.sv
// One mux channel: hold FSM, hold counter, capture flop and registered output.
module firebird7_in_gate1_tessent_data_mux_hold_ch
  import firebird7_in_gate1_tessent_data_mux_hold_pkg::*;
#(
  parameter int unsigned WIDTH       = 19,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_select,
  input  logic [WIDTH-1:0] functional_data_in,
  input  logic [WIDTH-1:0] ijtag_data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] capture_data_out,
  output logic             override_active
);

  localparam int unsigned CW       = cnt_width(HOLD_CYCLES);
  localparam int unsigned LOAD_VAL = (HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_VAL);
  localparam logic HAS_HOLD = (HOLD_CYCLES != 0);

  hold_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_d, cap_d;
  logic             ov_d;

  // Next state, counter reload/decrement and next output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_out;
    cap_d   = capture_data_out;
    case (state_q)
      IDLE: begin
        data_d = functional_data_in;
        if (ijtag_select) begin
          cap_d = functional_data_in;
          if (HAS_HOLD) begin
            state_d = HOLD;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = OVERRIDE;
          end
        end
      end
      HOLD: begin
        data_d = capture_data_out;
        if (!ijtag_select) begin
          state_d = RELEASE;
          cnt_d   = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = OVERRIDE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      OVERRIDE: begin
        data_d = ijtag_data_in;
        if (!ijtag_select) begin
          if (HAS_HOLD) begin
            state_d = RELEASE;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RELEASE: begin
        // Output keeps the last IJTAG value until the release hold expires.
        if (ijtag_select) begin
          state_d = OVERRIDE;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ov_d = (state_d != IDLE);
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      data_out         <= '0;
      capture_data_out <= '0;
      override_active  <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      data_out         <= data_d;
      capture_data_out <= cap_d;
      override_active  <= ov_d;
    end
  end

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_hold.sv
// NUM_CH independent bumpless IJTAG/functional mux channels on packed buses.
module firebird7_in_gate1_tessent_data_mux_hold #(
  parameter int unsigned WIDTH       = 19,
  parameter int unsigned NUM_CH      = 16,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                    ijtag_tck,
  input  logic                    ijtag_reset,
  input  logic [NUM_CH-1:0]       ijtag_select,
  input  logic [NUM_CH*WIDTH-1:0] functional_data_in,
  input  logic [NUM_CH*WIDTH-1:0] ijtag_data_in,
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic [NUM_CH*WIDTH-1:0] capture_data_out,
  output logic [NUM_CH-1:0]       override_active
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    firebird7_in_gate1_tessent_data_mux_hold_ch #(
      .WIDTH       (WIDTH),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_ch (
      .ijtag_tck          (ijtag_tck),
      .ijtag_reset        (ijtag_reset),
      .ijtag_select       (ijtag_select[c]),
      .functional_data_in (functional_data_in[c*WIDTH +: WIDTH]),
      .ijtag_data_in      (ijtag_data_in[c*WIDTH +: WIDTH]),
      .data_out           (data_out[c*WIDTH +: WIDTH]),
      .capture_data_out   (capture_data_out[c*WIDTH +: WIDTH]),
      .override_active    (override_active[c])
    );
  end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_hold.sv
// Scoreboard bench: hold-2 and hold-0 instances share stimulus; a monitor checks every cycle.
module tb_firebird7_in_gate1_tessent_data_mux_hold;

  localparam int unsigned W  = 19;
  localparam int unsigned NC = 16;
  localparam int unsigned NW = W * NC;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] sel;
  logic [NW-1:0] fd, id;
  logic [NW-1:0] d2, c2, d0, c0;
  logic [NC-1:0] o2, o0;

  firebird7_in_gate1_tessent_data_mux_hold #(.WIDTH(W), .NUM_CH(NC), .HOLD_CYCLES(2)) dut_h2 (
    .ijtag_tck(clk), .ijtag_reset(rst_n), .ijtag_select(sel),
    .functional_data_in(fd), .ijtag_data_in(id),
    .data_out(d2), .capture_data_out(c2), .override_active(o2));

  firebird7_in_gate1_tessent_data_mux_hold #(.WIDTH(W), .NUM_CH(NC), .HOLD_CYCLES(0)) dut_h0 (
    .ijtag_tck(clk), .ijtag_reset(rst_n), .ijtag_select(sel),
    .functional_data_in(fd), .ijtag_data_in(id),
    .data_out(d0), .capture_data_out(c0), .override_active(o0));

  always #5 clk = ~clk;

  typedef struct {
    logic [NW-1:0] d2, c2, d0, c0;
    logic [NC-1:0] o2, o0;
    bit            hen;
    bit            hdut0;
    int            hch;
    logic [W-1:0]  hd, hc;
    logic          ho;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state, index 0 = hold-2 instance, 1 = hold-0 instance
  int           m_st [2][NC];
  int           m_cnt[2][NC];
  logic [W-1:0] m_d  [2][NC];
  logic [W-1:0] m_c  [2][NC];

  bit           h_en = 0, h_dut0 = 0;
  int           h_ch = 0;
  logic [W-1:0] h_d = '0, h_c = '0;
  logic         h_o = 1'b0;

  logic [NC-1:0] cs;
  logic [NW-1:0] cf, ci;

  task automatic chk(input string nm, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] setch(input logic [NW-1:0] b, input int c, input logic [W-1:0] v);
    b[c*W +: W] = v;
    return b;
  endfunction

  function automatic logic [W-1:0] getch(input logic [NW-1:0] b, input int c);
    return b[c*W +: W];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NC; c++) begin
        m_st[k][c] = 0; m_cnt[k][c] = 0; m_d[k][c] = '0; m_c[k][c] = '0;
      end
  endtask

  // One clock edge of the behavioural model (0 idle, 1 hold, 2 override, 3 release)
  task automatic model_clock(input logic [NC-1:0] s, input logic [NW-1:0] f, input logic [NW-1:0] i);
    for (int k = 0; k < 2; k++) begin
      int h;
      h = (k == 0) ? 2 : 0;
      for (int c = 0; c < NC; c++) begin
        logic [W-1:0] fv, iv;
        fv = getch(f, c);
        iv = getch(i, c);
        case (m_st[k][c])
          0: begin
            m_d[k][c] = fv;
            if (s[c]) begin
              m_c[k][c] = fv;
              if (h > 0) begin m_st[k][c] = 1; m_cnt[k][c] = h - 1; end
              else m_st[k][c] = 2;
            end
          end
          1: begin
            m_d[k][c] = m_c[k][c];
            if (!s[c]) begin m_st[k][c] = 3; m_cnt[k][c] = h - 1; end
            else if (m_cnt[k][c] == 0) m_st[k][c] = 2;
            else m_cnt[k][c]--;
          end
          2: begin
            m_d[k][c] = iv;
            if (!s[c]) begin
              if (h > 0) begin m_st[k][c] = 3; m_cnt[k][c] = h - 1; end
              else m_st[k][c] = 0;
            end
          end
          default: begin
            if (s[c]) m_st[k][c] = 2;
            else if (m_cnt[k][c] == 0) m_st[k][c] = 0;
            else m_cnt[k][c]--;
          end
        endcase
      end
    end
  endtask

  // Drive inputs on the falling edge and queue the response expected after the next rising edge
  task automatic drive(input logic r, input logic [NC-1:0] s, input logic [NW-1:0] f, input logic [NW-1:0] i);
    exp_t e;
    logic was;
    @(negedge clk);
    was = rst_n;
    rst_n = r; sel = s; fd = f; id = i;
    if (!r) model_reset();
    else model_clock(s, f, i);
    for (int c = 0; c < NC; c++) begin
      e.d2[c*W +: W] = m_d[0][c];
      e.c2[c*W +: W] = m_c[0][c];
      e.d0[c*W +: W] = m_d[1][c];
      e.c0[c*W +: W] = m_c[1][c];
      e.o2[c] = (m_st[0][c] != 0);
      e.o0[c] = (m_st[1][c] != 0);
    end
    e.hen = h_en; e.hdut0 = h_dut0; e.hch = h_ch; e.hd = h_d; e.hc = h_c; e.ho = h_o;
    q.push_back(e);
    h_en = 0;
    if (was && !r) begin
      #1;
      chk("async_rst dout_h2", d2, '0);
      chk("async_rst cap_h2", c2, '0);
      chk("async_rst ov_h2", NW'(o2), '0);
      chk("async_rst dout_h0", d0, '0);
      chk("async_rst cap_h0", c0, '0);
      chk("async_rst ov_h0", NW'(o0), '0);
    end
  endtask

  task automatic hstep(input logic [NC-1:0] s, input bit dut0, input int ch,
                       input logic [W-1:0] d, input logic [W-1:0] c, input logic o);
    h_en = 1; h_dut0 = dut0; h_ch = ch; h_d = d; h_c = c; h_o = o;
    drive(1'b1, s, cf, ci);
  endtask

  // Monitor: outputs are presented every cycle; compare just after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dout_h2", d2, e.d2);
        chk("cap_h2", c2, e.c2);
        chk("ov_h2", NW'(o2), NW'(e.o2));
        chk("dout_h0", d0, e.d0);
        chk("cap_h0", c0, e.c0);
        chk("ov_h0", NW'(o0), NW'(e.o0));
        if (e.hen) begin
          chk($sformatf("hand_dout ch%0d", e.hch),
              NW'(e.hdut0 ? getch(d0, e.hch) : getch(d2, e.hch)), NW'(e.hd));
          chk($sformatf("hand_cap ch%0d", e.hch),
              NW'(e.hdut0 ? getch(c0, e.hch) : getch(c2, e.hch)), NW'(e.hc));
          chk($sformatf("hand_ov ch%0d", e.hch),
              NW'(e.hdut0 ? o0[e.hch] : o2[e.hch]), NW'(e.ho));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    cs = '0; cf = '0; ci = '0;
    for (int c = 0; c < NC; c++) begin
      cf = setch(cf, c, W'($urandom));
      ci = setch(ci, c, W'($urandom));
    end
    sel = NC'($urandom); fd = cf; id = ci;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("reset dout_h2", d2, '0);
    chk("reset cap_h2", c2, '0);
    chk("reset ov_h2", NW'(o2), '0);
    drive(1'b0, NC'($urandom), cf, ci);
    drive(1'b0, NC'($urandom), cf, ci);

    // Reset release: functional data reaches data_out after one edge
    cf = setch(cf, 0, 19'h01234);
    hstep(cs, 0, 0, 19'h01234, 19'h0, 1'b0);

    // Override entry on ch3 with a two-cycle hold
    cf = setch(cf, 3, 19'h0AAAA);
    ci = setch(ci, 3, 19'h05555);
    cs[3] = 1'b1;
    hstep(cs, 0, 3, 19'h0AAAA, 19'h0AAAA, 1'b1);
    hstep(cs, 0, 3, 19'h0AAAA, 19'h0AAAA, 1'b1);
    hstep(cs, 0, 3, 19'h0AAAA, 19'h0AAAA, 1'b1);
    hstep(cs, 0, 3, 19'h05555, 19'h0AAAA, 1'b1);
    hstep(cs, 0, 3, 19'h05555, 19'h0AAAA, 1'b1);

    // Override exit on ch3
    cs[3] = 1'b0;
    cf = setch(cf, 3, 19'h7FFFF);
    hstep(cs, 0, 3, 19'h05555, 19'h0AAAA, 1'b1);
    hstep(cs, 0, 3, 19'h05555, 19'h0AAAA, 1'b1);
    hstep(cs, 0, 3, 19'h05555, 19'h0AAAA, 1'b0);
    hstep(cs, 0, 3, 19'h7FFFF, 19'h0AAAA, 1'b0);

    // One-cycle select pulse on ch5 never exposes IJTAG data
    cf = setch(cf, 5, 19'h11111);
    ci = setch(ci, 5, 19'h22222);
    hstep(cs, 0, 5, 19'h11111, 19'h0, 1'b0);
    cs[5] = 1'b1;
    hstep(cs, 0, 5, 19'h11111, 19'h11111, 1'b1);
    cs[5] = 1'b0;
    cf = setch(cf, 5, 19'h33333);
    hstep(cs, 0, 5, 19'h11111, 19'h11111, 1'b1);
    hstep(cs, 0, 5, 19'h11111, 19'h11111, 1'b1);
    hstep(cs, 0, 5, 19'h11111, 19'h11111, 1'b0);
    hstep(cs, 0, 5, 19'h33333, 19'h11111, 1'b0);

    // All channels switch on the same edge with distinct data
    for (int c = 0; c < NC; c++) begin
      cf = setch(cf, c, W'(32'h01000 * c + 32'h00ABC + c));
      ci = setch(ci, c, W'(32'h7FFFF - 32'h02100 * c));
    end
    drive(1'b1, cs, cf, ci);
    cs = '1;
    for (int k = 0; k < 5; k++)
      hstep(cs, 0, 9, (k < 3) ? getch(cf, 9) : getch(ci, 9), getch(cf, 9), 1'b1);
    cs = '0;
    for (int k = 0; k < 5; k++)
      hstep(cs, 0, 9, (k < 3) ? getch(ci, 9) : getch(cf, 9), getch(cf, 9), (k < 2));
    for (int k = 0; k < 2; k++) drive(1'b1, 16'hA5A5, cf, ci);
    for (int k = 0; k < 5; k++) drive(1'b1, 16'h5A5A, cf, ci);
    for (int k = 0; k < 6; k++) drive(1'b1, '0, cf, ci);

    // Asynchronous reset mid-HOLD (hold-0 instance is in OVERRIDE)
    cs = '1;
    drive(1'b1, cs, cf, ci);
    drive(1'b1, cs, cf, ci);
    drive(1'b0, cs, cf, ci);
    drive(1'b0, cs, cf, ci);
    hstep(cs, 0, 0, getch(cf, 0), getch(cf, 0), 1'b1);
    for (int k = 0; k < 4; k++) drive(1'b1, cs, cf, ci);

    // Asynchronous reset mid-RELEASE, then restart from IDLE
    cs = '0;
    drive(1'b1, cs, cf, ci);
    drive(1'b0, cs, cf, ci);
    drive(1'b0, cs, cf, ci);
    hstep(cs, 0, 0, getch(cf, 0), 19'h0, 1'b0);

    // Zero-length hold: direct IDLE <-> OVERRIDE switch on ch1
    cf = setch(cf, 1, 19'h0F0F0);
    ci = setch(ci, 1, 19'h70707);
    hstep(cs, 1, 1, 19'h0F0F0, 19'h0, 1'b0);
    cs[1] = 1'b1;
    hstep(cs, 1, 1, 19'h0F0F0, 19'h0F0F0, 1'b1);
    hstep(cs, 1, 1, 19'h70707, 19'h0F0F0, 1'b1);
    cs[1] = 1'b0;
    hstep(cs, 1, 1, 19'h70707, 19'h0F0F0, 1'b0);
    hstep(cs, 1, 1, 19'h0F0F0, 19'h0F0F0, 1'b0);
    drive(1'b1, '1, cf, ci);
    drive(1'b1, '1, cf, ci);
    drive(1'b0, '1, cf, ci);
    drive(1'b1, '0, cf, ci);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #5;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
